// File: rtl/osd_text_renderer_v2_pkg.sv
// osd_v2_pkg: shared register map, CTRL layout, timeout lengths and default colours for the OSD renderer
package osd_v2_pkg;

    localparam logic [9:0] ADDR_CTRL   = 10'h3F0;
    localparam logic [9:0] ADDR_ROW_EN = 10'h3F1;

    localparam int CHAR_W = 9;

    localparam logic [9:0] TO_120 = 10'd120;
    localparam logic [9:0] TO_300 = 10'd300;
    localparam logic [9:0] TO_600 = 10'd600;

    localparam logic [2:0] BLACK  = 3'd0;
    localparam logic [2:0] BLUE   = 3'd1;
    localparam logic [2:0] YELLOW = 3'd6;
    localparam logic [2:0] WHITE  = 3'd7;

    typedef struct packed {
        logic [2:0] bg_col;
        logic [2:0] txt_col;
        logic [2:0] hl_col;
        logic [2:0] bd_col;
        logic [1:0] y_size;
        logic [1:0] x_size;
        logic [2:0] y_off;
        logic [2:0] x_off;
        logic [1:0] timeout;
        logic       menu;
        logic       refresh;
        logic       en;
    } ctrl_t;

    function automatic logic [9:0] to_frames(input logic [1:0] sel);
        return (sel == 2'd0) ? TO_120 : (sel == 2'd1) ? TO_300 : (sel == 2'd2) ? TO_600 : 10'd0;
    endfunction

endpackage

// File: rtl/osd_text_renderer_v2_if.sv
// osd_text_renderer_v2_if: register / char-RAM write bus with registered read-back
interface osd_text_renderer_v2_if;
    logic        reg_we;
    logic [9:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    modport master (output reg_we, reg_addr, reg_wdata, input reg_rdata);
    modport slave (input reg_we, reg_addr, reg_wdata, output reg_rdata);
endinterface

// File: rtl/osd_text_renderer_v2_char_ram.sv
// osd_char_ram: simple dual-port character RAM, synchronous read returning pre-write data on collision
module osd_char_ram
    import osd_v2_pkg::*;
#(
    parameter int DEPTH = 1000,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              vclk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [CHAR_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [CHAR_W-1:0] rdata
);

    logic [CHAR_W-1:0] mem [DEPTH];

    // write port and registered read port; non-blocking update gives read-old behaviour
    always_ff @(posedge vclk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/osd_text_renderer_v2.sv
// osd_text_renderer_v2: 5-stage text overlay with column sections, border, highlight, blink and status timeout
module osd_text_renderer_v2
    import osd_v2_pkg::*;
#(
    parameter int CHAR_ROWS    = 25,
    parameter int CHAR_COLS    = 20,
    parameter int SECTIONS     = 2,
    parameter int SEP_COLS     = 2,
    parameter int COLOR_W      = 3,
    parameter int XW           = 12,
    parameter int YW           = 11,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                 vclk,
    input  logic                 rst_i,
    osd_text_renderer_v2_if.slave bus,
    input  logic                 frame_start,
    input  logic [XW-1:0]        xpos,
    input  logic [YW-1:0]        ypos,
    output logic [10:0]          font_addr,
    input  logic [7:0]           font_data,
    output logic                 osd_enable,
    output logic [COLOR_W-1:0]   osd_color
);

    localparam int DEPTH = CHAR_ROWS * CHAR_COLS * SECTIONS;
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(BLINK_FRAMES);
    localparam logic [31:0] ROW_MASK = 32'hFFFF_FFFF >> (32 - CHAR_ROWS);
    localparam logic [9:0] ADDR_HL = ADDR_ROW_EN + 10'(SECTIONS);

    function automatic int sec_x0(input int s);
        return 8 * s * (CHAR_COLS + SEP_COLS);
    endfunction

    ctrl_t ctrl;
    logic [31:0] row_en [SECTIONS];
    logic [31:0] row_hl;
    logic [31:0] rd_c;
    logic [9:0] to_ctr;
    logic [BW-1:0] blink_ctr;
    logic refresh_w, visible, blink_off, glyph, ram_we;
    logic signed [XW:0] xs1;
    logic signed [YW:0] ys1;
    int xi, yi, q;
    logic text_c, area_c, hl_c;
    logic [AW-1:0] idx_c;
    logic [CHAR_W-1:0] ram_q;
    logic text2, area2, hl2, text3, area3, hl3, blink3, text4, area4, hl4, blink4;
    logic [2:0] xb2, xb3, xb4, gy2;

    assign refresh_w = bus.reg_we && bus.reg_addr == ADDR_CTRL && bus.reg_wdata[1];
    assign visible = ctrl.en & (ctrl.menu | (to_ctr != 10'd0));
    assign blink_off = blink_ctr >= BW'(BLINK_FRAMES / 2);
    assign glyph = font_data[3'd7 - xb4];
    assign ram_we = bus.reg_we && bus.reg_addr < 10'(DEPTH);

    // configuration registers; refresh is a strobe so it is never held
    always_ff @(posedge vclk or posedge rst_i) begin
        if (rst_i) begin
            ctrl <= '0;
            row_hl <= '0;
            for (int s = 0; s < SECTIONS; s++) row_en[s] <= '0;
        end else if (bus.reg_we) begin
            if (bus.reg_addr == ADDR_CTRL) ctrl <= ctrl_t'({bus.reg_wdata[26:2], 1'b0, bus.reg_wdata[0]});
            if (bus.reg_addr == ADDR_HL) row_hl <= bus.reg_wdata & ROW_MASK;
            for (int s = 0; s < SECTIONS; s++)
                if (bus.reg_addr == ADDR_ROW_EN + 10'(s)) row_en[s] <= bus.reg_wdata & ROW_MASK;
        end
    end

    // read-back mux; char RAM is write-only from the bus since its read port belongs to the renderer
    always_comb begin
        rd_c = '0;
        if (bus.reg_addr == ADDR_CTRL) rd_c = 32'(ctrl);
        if (bus.reg_addr == ADDR_HL) rd_c = row_hl;
        for (int s = 0; s < SECTIONS; s++)
            if (bus.reg_addr == ADDR_ROW_EN + 10'(s)) rd_c = row_en[s];
    end

    // registered read data
    always_ff @(posedge vclk or posedge rst_i) begin
        if (rst_i) bus.reg_rdata <= '0;
        else bus.reg_rdata <= rd_c;
    end

    // status timeout (refresh beats frame_start) and free-running blink phase
    always_ff @(posedge vclk or posedge rst_i) begin
        if (rst_i) begin
            to_ctr <= '0;
            blink_ctr <= '0;
        end else begin
            if (refresh_w) to_ctr <= to_frames(bus.reg_wdata[4:3]);
            else if (frame_start && to_ctr != 10'd0) to_ctr <= to_ctr - 10'd1;
            if (frame_start) blink_ctr <= (blink_ctr == BW'(BLINK_FRAMES - 1)) ? '0 : blink_ctr + 1'b1;
        end
    end

    // S1: scale and offset the pixel position into signed text-space coordinates
    always_ff @(posedge vclk or posedge rst_i) begin
        if (rst_i) begin
            xs1 <= '0;
            ys1 <= '0;
        end else begin
            xs1 <= $signed({1'b0, xpos >> ctrl.x_size}) - $signed({{(XW - 5){1'b0}}, ctrl.x_off, 3'b000});
            ys1 <= $signed({1'b0, ypos >> ctrl.y_size}) - $signed({{(YW - 5){1'b0}}, ctrl.y_off, 3'b000});
        end
    end

    // S2 decode: text hit, char index, and border hit within 4 px of any enabled row rectangle
    always_comb begin
        xi = int'(xs1);
        yi = int'(ys1);
        q = (yi + 4) >>> 3;
        text_c = 1'b0;
        area_c = 1'b0;
        idx_c = '0;
        hl_c = row_hl[yi[7:3]];
        for (int s = 0; s < SECTIONS; s++) begin
            if (yi >= 0 && yi < 8 * CHAR_ROWS && xi >= sec_x0(s) && xi < sec_x0(s) + 8 * CHAR_COLS && row_en[s][yi[7:3]]) begin
                text_c = visible;
                idx_c = AW'((s * CHAR_ROWS + yi / 8) * CHAR_COLS + (xi - sec_x0(s)) / 8);
            end
            if (xi >= sec_x0(s) - 4 && xi < sec_x0(s) + 8 * CHAR_COLS + 4 &&
                ((q >= 0 && q < CHAR_ROWS && row_en[s][q[4:0]]) || (q >= 1 && q <= CHAR_ROWS && row_en[s][q[4:0] - 5'd1])))
                area_c = visible;
        end
    end

    osd_char_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .vclk  (vclk),
        .we    (ram_we),
        .waddr (bus.reg_addr[AW-1:0]),
        .wdata (bus.reg_wdata[CHAR_W-1:0]),
        .raddr (idx_c),
        .rdata (ram_q)
    );

    // S2-S4 pipeline: flags travel alongside the RAM read, font address and font ROM return
    always_ff @(posedge vclk or posedge rst_i) begin
        if (rst_i) begin
            {text2, area2, hl2, xb2, gy2} <= '0;
            {text3, area3, hl3, blink3, xb3} <= '0;
            {text4, area4, hl4, blink4, xb4} <= '0;
            font_addr <= '0;
        end else begin
            {text2, area2, hl2, xb2, gy2} <= {text_c, area_c, hl_c, xs1[2:0], ys1[2:0]};
            {text3, area3, hl3, blink3, xb3} <= {text2, area2, hl2, ram_q[8], xb2};
            font_addr <= {ram_q[7:0], gy2};
            {text4, area4, hl4, blink4, xb4} <= {text3, area3, hl3, blink3, xb3};
        end
    end

    // S5: pick the glyph bit and resolve the overlay colour
    always_ff @(posedge vclk or posedge rst_i) begin
        if (rst_i) begin
            osd_enable <= 1'b0;
            osd_color <= '0;
        end else begin
            osd_enable <= text4 | area4;
            osd_color <= text4 ? ((glyph && !(blink4 && blink_off)) ? (hl4 ? COLOR_W'(ctrl.hl_col) : COLOR_W'(ctrl.txt_col)) : COLOR_W'(ctrl.bg_col))
                       : area4 ? COLOR_W'(ctrl.bd_col) : '0;
        end
    end

endmodule
